if_stage: RTL and testbench

Instruction-fetch stage of the 6-stage IITB-RISC pipeline. It sits directly upstream of the instruction memory and owns the program counter. It drives the fetch address into the combinational instruction ROM and captures the returned word into the IF/ID pipeline register for decode. It handles stalls from the hazard unit, flushes, PC redirects from branch/jump resolution, and a halt when fetch runs past the populated ROM window.

---
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage.sv | 125 ++++++++++++
 tb/tb_if_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and
// the IF/ID pipeline register outputs. The master side is the fetch stage.
interface if_stage_if;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_next;
  logic        id_valid;
  logic        halted;

  modport master (
    output imem_pc, id_instr, id_pc, id_pc_next, id_valid, halted,
    input  imem_instr, stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_pc, id_instr, id_pc, id_pc_next, id_valid, halted,
    output imem_instr, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the IITB-RISC pipeline. Owns the PC, drives the
// combinational instruction ROM and fills the IF/ID register. Handles stall,
// flush, redirect and a HALT state once fetch leaves the ROM window.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_LIMIT = 16'd32,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  fetch
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic [15:0] id_instr, id_instr_d;
  logic [15:0] id_pc, id_pc_d;
  logic [15:0] id_pc_next, id_pc_next_d;
  logic        id_valid, id_valid_d;
  logic [15:0] target;

  // Redirect targets are forced to halfword alignment.
  assign target = fetch.redirect_pc & 16'hFFFE;

  // The PC feeds the ROM directly so the fetch address is glitch-free.
  assign fetch.imem_pc    = pc;
  assign fetch.id_instr   = id_instr;
  assign fetch.id_pc      = id_pc;
  assign fetch.id_pc_next = id_pc_next;
  assign fetch.id_valid   = id_valid;
  assign fetch.halted     = (state == HALT);

`ifdef IF_PERF_CNT_EN
  logic fetch_inc, stall_inc;
`endif

  // Next-state and next-register values; redirect beats halt check beats stall.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state;
    pc_d         = pc;
    id_instr_d   = id_instr;
    id_pc_d      = id_pc;
    id_pc_next_d = id_pc_next;
    id_valid_d   = id_valid;
`ifdef IF_PERF_CNT_EN
    fetch_inc    = 1'b0;
    stall_inc    = fetch.stall & ~fetch.redirect_valid & (state == RUN);
`endif
    case (state)
      RUN: begin
        if (fetch.redirect_valid) begin
          pc_d       = target;
          id_valid_d = 1'b0;
        end else if (pc >= PC_LIMIT) begin
          state_d    = HALT;
          id_valid_d = 1'b0;
        end else if (fetch.stall) begin
          if (fetch.flush) id_valid_d = 1'b0;
        end else begin
          id_instr_d   = fetch.imem_instr;
          id_pc_d      = pc;
          id_pc_next_d = pc + PC_STEP;
          id_valid_d   = ~fetch.flush;
          pc_d         = pc + PC_STEP;
`ifdef IF_PERF_CNT_EN
          fetch_inc    = ~fetch.flush;
`endif
        end
      end
      HALT: begin
        id_valid_d = 1'b0;
        if (fetch.redirect_valid) begin
          pc_d = target;
          if (target < PC_LIMIT) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, PC and IF/ID register update.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      id_instr   <= '0;
      id_pc      <= '0;
      id_pc_next <= '0;
      id_valid   <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      id_instr   <= id_instr_d;
      id_pc      <= id_pc_d;
      id_pc_next <= id_pc_next_d;
      id_valid   <= id_valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating performance counters, untouched by HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_inc && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (stall_inc && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. Two instances (default window and a
// PC_LIMIT=16'hFFFF wrap instance) share clock and controls; each is compared
// every cycle against a transaction-level reference model, plus directed
// checks with fixed expected values.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus_a ();
  if_stage_if bus_w ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt_a, scnt_a, fcnt_w, scnt_w;
`endif

  if_stage dut_a (
    .clk(clk), .rst(rst), .fetch(bus_a.master)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fcnt_a), .stall_count(scnt_a)
`endif
  );

  if_stage #(.PC_LIMIT(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .fetch(bus_w.master)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fcnt_w), .stall_count(scnt_w)
`endif
  );

  // Instruction ROM: 16 populated words, a scrambled pattern elsewhere.
  logic [15:0] rom [16];

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a < 16'd32) return rom[a[4:1]];
    return a ^ 16'hC3A5;
  endfunction

  assign bus_a.imem_instr = rom_word(bus_a.imem_pc);
  assign bus_w.imem_instr = rom_word(bus_w.imem_pc);

  // Controls, fanned out to both instances.
  logic        stall, flush, rv;
  logic [15:0] rpc;
  assign bus_a.stall = stall;  assign bus_w.stall = stall;
  assign bus_a.flush = flush;  assign bus_w.flush = flush;
  assign bus_a.redirect_valid = rv;  assign bus_w.redirect_valid = rv;
  assign bus_a.redirect_pc = rpc;    assign bus_w.redirect_pc = rpc;

  // Reference model of what the stage has delivered.
  typedef struct {
    bit          halted;
    logic [15:0] pc, instr, ipc, inext;
    bit          valid;
    logic [31:0] fcnt, scnt;
  } mdl_t;

  mdl_t ma, mw;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.halted = 0; m.pc = 16'h0000; m.instr = 0; m.ipc = 0; m.inext = 0;
    m.valid = 0; m.fcnt = 0; m.scnt = 0;
    return m;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic [15:0] limit);
    logic [15:0] tgt;
    tgt = {rpc[15:1], 1'b0};
    if (m.halted) begin
      m.valid = 0;
      if (rv) begin
        m.pc = tgt;
        if (tgt < limit) m.halted = 0;
      end
      return m;
    end
    if (stall && !rv) m.scnt = sat_inc(m.scnt);
    if (rv) begin
      m.pc = tgt; m.valid = 0;
    end else if (m.pc >= limit) begin
      m.halted = 1; m.valid = 0;
    end else if (stall) begin
      if (flush) m.valid = 0;
    end else begin
      m.instr = rom_word(m.pc);
      m.ipc   = m.pc;
      m.inext = m.pc + 16'd2;
      m.valid = !flush;
      if (!flush) m.fcnt = sat_inc(m.fcnt);
      m.pc    = m.pc + 16'd2;
    end
    return m;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cmp_a();
    check("a.imem_pc", bus_a.imem_pc, ma.pc);
    check("a.id_instr", bus_a.id_instr, ma.instr);
    check("a.id_pc", bus_a.id_pc, ma.ipc);
    check("a.id_pc_next", bus_a.id_pc_next, ma.inext);
    check("a.id_valid", bus_a.id_valid, ma.valid);
    check("a.halted", bus_a.halted, ma.halted);
`ifdef IF_PERF_CNT_EN
    check("a.fetch_count", fcnt_a, ma.fcnt);
    check("a.stall_count", scnt_a, ma.scnt);
`endif
  endtask

  task automatic cmp_w();
    check("w.imem_pc", bus_w.imem_pc, mw.pc);
    check("w.id_instr", bus_w.id_instr, mw.instr);
    check("w.id_pc", bus_w.id_pc, mw.ipc);
    check("w.id_pc_next", bus_w.id_pc_next, mw.inext);
    check("w.id_valid", bus_w.id_valid, mw.valid);
    check("w.halted", bus_w.halted, mw.halted);
`ifdef IF_PERF_CNT_EN
    check("w.fetch_count", fcnt_w, mw.fcnt);
    check("w.stall_count", scnt_w, mw.scnt);
`endif
  endtask

  // One clock edge: advance the models with the applied controls, then
  // sample the DUTs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    ma = mdl_step(ma, 16'd32);
    mw = mdl_step(mw, 16'hFFFF);
    #1;
    cmp_a();
    cmp_w();
  endtask

  task automatic idle();
    stall = 0; flush = 0; rv = 0; rpc = 16'h0000;
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic pulse_reset();
    #1 rst = 1;
    #1;
    ma = mdl_reset();
    mw = mdl_reset();
    check("rst.imem_pc", bus_a.imem_pc, 16'h0000);
    check("rst.id_valid", bus_a.id_valid, 0);
    check("rst.halted", bus_a.halted, 0);
    cmp_a();
    cmp_w();
    rst = 0;
  endtask

  initial begin
    rom[0] = 16'hB607;
    rom[1] = 16'h1360;
    for (int i = 2; i < 16; i++) rom[i] = 16'h2000 + 16'(i) * 16'h0513;
    idle();
    ma = mdl_reset();
    mw = mdl_reset();

    // Reset state.
    #12;
    check("reset.imem_pc", bus_a.imem_pc, 16'h0000);
    check("reset.id_instr", bus_a.id_instr, 16'h0000);
    check("reset.id_valid", bus_a.id_valid, 0);
    check("reset.halted", bus_a.halted, 0);
    cmp_a();
    cmp_w();
    rst = 0;

    // First two fetches.
    tick();
    check("e1.id_instr", bus_a.id_instr, 16'hB607);
    check("e1.id_pc", bus_a.id_pc, 16'h0000);
    check("e1.id_pc_next", bus_a.id_pc_next, 16'h0002);
    check("e1.id_valid", bus_a.id_valid, 1);
    tick();
    check("e2.id_instr", bus_a.id_instr, 16'h1360);
    check("e2.id_pc", bus_a.id_pc, 16'h0002);

    // Three-cycle stall at pc=6.
    tick();
    check("pre_stall.imem_pc", bus_a.imem_pc, 16'h0006);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.imem_pc", bus_a.imem_pc, 16'h0006);
      check("stall.id_pc", bus_a.id_pc, 16'h0004);
      check("stall.id_instr", bus_a.id_instr, rom[2]);
    end
    stall = 0;
    tick();
    check("unstall.id_pc", bus_a.id_pc, 16'h0006);
    check("unstall.id_instr", bus_a.id_instr, rom[3]);
`ifdef IF_PERF_CNT_EN
    check("unstall.stall_count", scnt_a, 3);
`endif

    // Redirect during stall, odd target gets aligned.
    stall = 1; rv = 1; rpc = 16'h0013;
    tick();
    check("redir.imem_pc", bus_a.imem_pc, 16'h0012);
    check("redir.id_valid", bus_a.id_valid, 0);
    idle();
    tick();
    check("redir_t.id_pc", bus_a.id_pc, 16'h0012);
    check("redir_t.id_valid", bus_a.id_valid, 1);

    // Run into HALT at pc=32 (bounded).
    for (int n = 0; n < 40 && !ma.halted; n++) tick();
    check("halt.halted", bus_a.halted, 1);
    check("halt.id_valid", bus_a.id_valid, 0);
    check("halt.imem_pc", bus_a.imem_pc, 16'd32);
    stall = 1; flush = 1;
    tick();
    check("halt_hold.imem_pc", bus_a.imem_pc, 16'd32);
    check("halt_hold.halted", bus_a.halted, 1);
    idle(); rv = 1; rpc = 16'h0004;
    tick();
    check("unhalt.halted", bus_a.halted, 0);
    check("unhalt.id_valid", bus_a.id_valid, 0);
    idle();
    tick();
    check("unhalt.id_pc", bus_a.id_pc, 16'h0004);
    check("unhalt.id_valid1", bus_a.id_valid, 1);

    // Flush without and with stall at pc=8.
    tick();
    check("pre_flush.imem_pc", bus_a.imem_pc, 16'h0008);
    flush = 1;
    tick();
    check("flush.id_valid", bus_a.id_valid, 0);
    check("flush.imem_pc", bus_a.imem_pc, 16'h000A);
    stall = 1;
    tick();
    check("flush_stall.id_valid", bus_a.id_valid, 0);
    check("flush_stall.imem_pc", bus_a.imem_pc, 16'h000A);
    idle();

    // PC wrap on the wide-window instance.
    rv = 1; rpc = 16'hFFFE;
    tick();
    check("wrap.imem_pc", bus_w.imem_pc, 16'hFFFE);
    idle();
    tick();
    check("wrap.id_pc", bus_w.id_pc, 16'hFFFE);
    check("wrap.id_pc_next", bus_w.id_pc_next, 16'h0000);
    check("wrap.imem_pc0", bus_w.imem_pc, 16'h0000);
    check("wrap.halted", bus_w.halted, 0);
    tick();
    check("wrap.id_pc0", bus_w.id_pc, 16'h0000);
    check("wrap.id_valid", bus_w.id_valid, 1);

    // Mid-operation reset with busy controls.
    stall = 1; flush = 1;
    pulse_reset();
    idle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(99) < 30);
      flush = ($urandom_range(99) < 15);
      rv    = ($urandom_range(99) < 8);
      if ($urandom_range(3) == 0) rpc = 16'($urandom);
      else rpc = 16'($urandom_range(40));
      if ($urandom_range(199) == 0) pulse_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
